micro_tlb: RTL and testbench
============================

Name: micro_tlb

Overview:
Parametrised per-port translation cache (micro-TLB) placed between a pipeline fetch/memory stage and the shared joint TLB. It translates one virtual address per request, serving hits from ENTRIES fully-associative 4 KB-page entries. On a miss it runs a refill handshake to the joint TLB and installs the result. Unmapped segments, uncached attributes and user-mode legality follow the existing MMU address-map rules.

Parameters:
ENTRIES, 4, number of cached translations (power of two, >=2)
ASID_WIDTH, 8, address-space identifier width
IS_DATA, 1, 1: dirty taken from the entry; 0 (instruction port): resp_dirty forced to 0

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
asid  input  ASID_WIDTH  current ASID
kseg0_uncached  input  1  kseg0 is uncached
is_user_mode  input  1  user mode
flush  input  1  invalidate all entries (TLBWI/TLBWR/ASID change)
req_valid  input  1  translation request
req_ready  output  1  request accepted this cycle
req_vaddr  input  32  virtual address
resp_valid  output  1  one-cycle result pulse
resp_paddr  output  32  physical address
resp_miss  output  1  joint-TLB refill miss
resp_invalid  output  1  mapped page not valid
resp_dirty  output  1  page writable
resp_uncached  output  1  uncached access
resp_illegal  output  1  user access to vaddr[31]=1
refill_valid  output  1  refill request to joint TLB
refill_vpn  output  20  requested VPN
refill_asid  output  ASID_WIDTH  requested ASID
refill_ready  input  1  joint-TLB reply valid (accepts request)
refill_hit  input  1  joint TLB matched
refill_pfn  input  20  PFN
refill_v  input  1  valid bit
refill_d  input  1  dirty bit
refill_c  input  3  cache attribute
refill_g  input  1  global bit

Behaviour:
- Reset: all entry valid bits 0, round-robin pointer 0, state IDLE, every output 0 (req_ready rises the cycle after reset deasserts).
- Address map: mapped = ~va[31] | va[31:30]==2'b11. Unmapped paddr = {3'b0, va[28:0]}. uncached = va[31:29]==3'b101 | (kseg0_uncached & va[31:29]==3'b100) | (mapped & cflag==3'd2). Unmapped dirty=1 (IS_DATA=1).
- req_ready = (state==IDLE) & ~flush. Accept when req_valid & req_ready; vaddr and asid are captured.
- Hit: entry valid & vpn==va[31:12] & (g | entry_asid==asid). At most one entry matches. Unmapped, illegal, or hit -> resp_valid exactly 1 cycle after acceptance with registered fields; state stays IDLE, so back-to-back requests are allowed.
- FSM IDLE -> REFILL on a mapped, legal miss. In REFILL, refill_valid=1 with refill_vpn/refill_asid held stable until the cycle refill_ready=1. On that edge: resp_valid next cycle, state -> IDLE.
- Reply mapping: resp_miss = ~refill_hit; resp_invalid = refill_hit & ~refill_v; paddr = {refill_pfn, va[11:0]}.
- Install only if refill_hit & refill_v and no flush was seen since the request was accepted.
- Victim selection: lowest-index invalid entry, else the round-robin pointer. The pointer increments (wraps ENTRIES-1 -> 0) only on installs that replace a valid entry.
- flush clears all valid bits on the next edge. Flush in the same cycle as an install: flush wins, nothing is written. Flush during REFILL: the request continues, the response is still delivered, no install.
- refill_ready while in IDLE is ignored.
- Reset mid-REFILL: refill_valid drops immediately (async), no response issued.
- resp_illegal = is_user_mode & va[31]; no lookup or refill is performed. Illegal responses report miss/invalid=0.
- Latency: hit 1 cycle; miss 2 + (cycles until refill_ready) cycles.

Test Plan:
1. After reset, request va=0x8000_1234 with kseg0_uncached=0 -> next cycle resp_valid, paddr=0x0000_1234, uncached=0, dirty=1, no refill_valid.
2. Request va=0x0040_0010, asid=5 -> refill_valid with vpn=0x00400, asid=5; reply hit/v/d=1, pfn=0x1F000, c=3 -> paddr=0x1F00_0010. Repeat request -> hit in 1 cycle, no refill.
3. Joint TLB returns refill_hit=0 -> resp_miss=1, not installed; the same request refills again.
4. Fill ENTRIES+1 distinct pages (ENTRIES=4) -> the 5th replaces entry 0, pointer=1; page 0 then misses and pages 1-4 hit.
5. Assert flush while refill is pending, then reply valid -> response delivered, subsequent same-page request misses.
6. is_user_mode=1, va=0xC000_0000 -> resp_illegal=1 next cycle, no refill_valid; assert reset in REFILL -> refill_valid=0 immediately.

Source files
------------

// File: rtl/micro_tlb.sv
// Per-port micro-TLB: fully-associative cache of 4 KB translations in front of the joint TLB.
// Serves hits and unmapped segments in one cycle; misses run a refill handshake and install the reply.
module micro_tlb #(
    parameter int ENTRIES    = 4,
    parameter int ASID_WIDTH = 8,
    parameter int IS_DATA    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ASID_WIDTH-1:0] asid,
    input  logic                  kseg0_uncached,
    input  logic                  is_user_mode,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_vaddr,
    output logic                  resp_valid,
    output logic [31:0]           resp_paddr,
    output logic                  resp_miss,
    output logic                  resp_invalid,
    output logic                  resp_dirty,
    output logic                  resp_uncached,
    output logic                  resp_illegal,
    output logic                  refill_valid,
    output logic [19:0]           refill_vpn,
    output logic [ASID_WIDTH-1:0] refill_asid,
    input  logic                  refill_ready,
    input  logic                  refill_hit,
    input  logic [19:0]           refill_pfn,
    input  logic                  refill_v,
    input  logic                  refill_d,
    input  logic [2:0]            refill_c,
    input  logic                  refill_g
);
    localparam int   IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic DATA_PORT = (IS_DATA != 0);

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t                r_state;
    logic                  r_active;
    logic [31:0]           r_va;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_flush_seen;
    logic [IDX_W-1:0]      r_ptr;
    logic [ENTRIES-1:0]    r_valid;
    logic [19:0]           r_vpn  [ENTRIES];
    logic [ASID_WIDTH-1:0] r_easid[ENTRIES];
    logic [19:0]           r_pfn  [ENTRIES];
    logic                  r_d    [ENTRIES];
    logic [2:0]            r_c    [ENTRIES];
    logic                  r_g    [ENTRIES];

    logic                  r_resp_valid;
    logic [31:0]           r_paddr;
    logic                  r_miss;
    logic                  r_invalid;
    logic                  r_dirty;
    logic                  r_uncached;
    logic                  r_illegal;

    logic                  w_mapped;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_install;
    logic [ENTRIES-1:0]    w_hit_vec;
    logic                  w_any_hit;
    logic [19:0]           w_hit_pfn;
    logic                  w_hit_d;
    logic [2:0]            w_hit_c;
    logic [IDX_W-1:0]      w_victim;

    function automatic logic f_uncached(input logic [31:0] va, input logic mapped,
                                        input logic [2:0] cflag, input logic k0u);
        return (va[31:29] == 3'b101) | (k0u & (va[31:29] == 3'b100)) |
               (mapped & (cflag == 3'd2));
    endfunction

    assign w_mapped  = ~req_vaddr[31] | (req_vaddr[31:30] == 2'b11);
    assign w_illegal = is_user_mode & req_vaddr[31];
    assign req_ready = r_active & (r_state == S_IDLE) & ~flush;
    assign w_accept  = req_valid & req_ready;
    // A flush seen at any point of the refill, including the reply cycle, blocks the install.
    assign w_install = (r_state == S_REFILL) & refill_ready & refill_hit & refill_v &
                       ~r_flush_seen & ~flush;

    always_comb begin
        w_hit_vec = '0;
        w_hit_pfn = '0;
        w_hit_d   = 1'b0;
        w_hit_c   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_hit_vec[i] = r_valid[i] & (r_vpn[i] == req_vaddr[31:12]) &
                           (r_g[i] | (r_easid[i] == asid));
            w_hit_pfn = w_hit_pfn | ({20{w_hit_vec[i]}} & r_pfn[i]);
            w_hit_d   = w_hit_d | (w_hit_vec[i] & r_d[i]);
            w_hit_c   = w_hit_c | ({3{w_hit_vec[i]}} & r_c[i]);
        end
    end
    assign w_any_hit = |w_hit_vec;

    // Descending scan so the lowest-index free slot is the one left selected.
    always_comb begin
        w_victim = r_ptr;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (!r_valid[i-1]) w_victim = IDX_W'(i - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_active     <= 1'b0;
            r_va         <= '0;
            r_asid       <= '0;
            r_flush_seen <= 1'b0;
            r_ptr        <= '0;
            r_valid      <= '0;
            r_resp_valid <= 1'b0;
            r_paddr      <= '0;
            r_miss       <= 1'b0;
            r_invalid    <= 1'b0;
            r_dirty      <= 1'b0;
            r_uncached   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_active     <= 1'b1;
            r_resp_valid <= 1'b0;
            if (flush) r_flush_seen <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_va         <= req_vaddr;
                        r_asid       <= asid;
                        r_flush_seen <= 1'b0;
                        if (w_illegal) begin
                            r_resp_valid <= 1'b1;
                            r_paddr      <= '0;
                            r_miss       <= 1'b0;
                            r_invalid    <= 1'b0;
                            r_dirty      <= 1'b0;
                            r_uncached   <= 1'b0;
                            r_illegal    <= 1'b1;
                        end else if (!w_mapped) begin
                            r_resp_valid <= 1'b1;
                            r_paddr      <= {3'b000, req_vaddr[28:0]};
                            r_miss       <= 1'b0;
                            r_invalid    <= 1'b0;
                            r_dirty      <= DATA_PORT;
                            r_uncached   <= f_uncached(req_vaddr, 1'b0, 3'd0, kseg0_uncached);
                            r_illegal    <= 1'b0;
                        end else if (w_any_hit) begin
                            r_resp_valid <= 1'b1;
                            r_paddr      <= {w_hit_pfn, req_vaddr[11:0]};
                            r_miss       <= 1'b0;
                            r_invalid    <= 1'b0;
                            r_dirty      <= DATA_PORT & w_hit_d;
                            r_uncached   <= f_uncached(req_vaddr, 1'b1, w_hit_c, kseg0_uncached);
                            r_illegal    <= 1'b0;
                        end else begin
                            r_state <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (refill_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b1;
                        r_paddr      <= {refill_pfn, r_va[11:0]};
                        r_miss       <= ~refill_hit;
                        r_invalid    <= refill_hit & ~refill_v;
                        r_dirty      <= DATA_PORT & refill_hit & refill_v & refill_d;
                        r_uncached   <= f_uncached(r_va, 1'b1,
                                                   (refill_hit & refill_v) ? refill_c : 3'd0,
                                                   kseg0_uncached);
                        r_illegal    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (flush) begin
                r_valid <= '0;
            end else if (w_install) begin
                r_valid[w_victim] <= 1'b1;
                if (r_valid[w_victim]) r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_vpn[w_victim]   <= r_va[31:12];
            r_easid[w_victim] <= r_asid;
            r_pfn[w_victim]   <= refill_pfn;
            r_d[w_victim]     <= refill_d;
            r_c[w_victim]     <= refill_c;
            r_g[w_victim]     <= refill_g;
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_paddr    = r_paddr;
    assign resp_miss     = r_miss;
    assign resp_invalid  = r_invalid;
    assign resp_dirty    = r_dirty;
    assign resp_uncached = r_uncached;
    assign resp_illegal  = r_illegal;
    assign refill_valid  = (r_state == S_REFILL);
    assign refill_vpn    = r_va[31:12];
    assign refill_asid   = r_asid;
endmodule

// File: tb/tb_micro_tlb.sv
// Bench for micro_tlb: address-map vector table, directed refill/flush/reset sequences,
// and randomized traffic checked against an array-based cache model.
module tb_micro_tlb;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  asid;
    logic        kseg0_uncached, is_user_mode, flush;
    logic        req_valid, req_ready;
    logic [31:0] req_vaddr;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_miss, resp_invalid, resp_dirty, resp_uncached, resp_illegal;
    logic        refill_valid;
    logic [19:0] refill_vpn;
    logic [7:0]  refill_asid;
    logic        refill_ready, refill_hit, refill_v, refill_d, refill_g;
    logic [19:0] refill_pfn;
    logic [2:0]  refill_c;

    micro_tlb #(.ENTRIES(4), .ASID_WIDTH(8), .IS_DATA(1)) dut (
        .clk(clk), .reset(reset), .asid(asid), .kseg0_uncached(kseg0_uncached),
        .is_user_mode(is_user_mode), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready), .req_vaddr(req_vaddr), .resp_valid(resp_valid),
        .resp_paddr(resp_paddr), .resp_miss(resp_miss), .resp_invalid(resp_invalid),
        .resp_dirty(resp_dirty), .resp_uncached(resp_uncached), .resp_illegal(resp_illegal),
        .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_asid(refill_asid),
        .refill_ready(refill_ready), .refill_hit(refill_hit), .refill_pfn(refill_pfn),
        .refill_v(refill_v), .refill_d(refill_d), .refill_c(refill_c), .refill_g(refill_g)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference cache: 4 slots, lowest free slot first, else round-robin victim.
    bit        m_valid[4];
    bit [19:0] m_vpn[4];
    bit [19:0] m_pfn[4];
    bit [7:0]  m_asid[4];
    bit        m_d[4];
    bit        m_g[4];
    bit [2:0]  m_c[4];
    int        m_ptr;

    function automatic void m_flush();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
    endfunction

    function automatic int m_lookup(input bit [19:0] vpn, input bit [7:0] as);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == as)) return i;
        return -1;
    endfunction

    function automatic void m_install(input bit [19:0] vpn, input bit [7:0] as,
                                      input bit [19:0] pfn, input bit d, input bit [2:0] c,
                                      input bit g);
        int slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
        end
        m_valid[slot] = 1; m_vpn[slot] = vpn; m_asid[slot] = as;
        m_pfn[slot] = pfn; m_d[slot] = d; m_c[slot] = c; m_g[slot] = g;
    endfunction

    // Joint TLB keeps the global bit a property of the page.
    function automatic logic jg(input logic [19:0] vpn);
        return vpn[2:0] == 3'd5;
    endfunction

    task automatic txn(input logic [31:0] va, input logic [7:0] as, input logic user,
                       input logic k0u, input int delay, input int flush_at,
                       input logic jhit, input logic jv, input logic jd,
                       input logic [2:0] jc, input logic [19:0] jpfn, output logic refilled);
        logic        mapped, ill, flushed;
        logic [19:0] vpn;
        int          idx;
        vpn      = va[31:12];
        refilled = 1'b0;
        @(negedge clk);
        chk("resp_pulse", resp_valid, 0);
        asid = as; is_user_mode = user; kseg0_uncached = k0u; req_vaddr = va; req_valid = 1'b1;
        #1 chk("req_ready", req_ready, 1);
        mapped = !va[31] || va[31:30] == 2'b11;
        ill    = user && va[31];
        idx    = (mapped && !ill) ? m_lookup(vpn, as) : -1;
        @(negedge clk);
        req_valid = 1'b0;
        if (ill) begin
            chk("ill_valid", resp_valid, 1);
            chk("ill_flag", resp_illegal, 1);
            chk("ill_miss", {resp_miss, resp_invalid}, 0);
            chk("ill_norefill", refill_valid, 0);
        end else if (!mapped) begin
            chk("unm_valid", resp_valid, 1);
            chk("unm_paddr", resp_paddr, {3'b000, va[28:0]});
            chk("unm_unc", resp_uncached, (va[31:29] == 3'b101) || (k0u && va[31:29] == 3'b100));
            chk("unm_dirty", resp_dirty, 1);
            chk("unm_norefill", refill_valid, 0);
        end else if (idx >= 0) begin
            chk("hit_valid", resp_valid, 1);
            chk("hit_paddr", resp_paddr, {m_pfn[idx], va[11:0]});
            chk("hit_unc", resp_uncached, m_c[idx] == 3'd2);
            chk("hit_dirty", resp_dirty, m_d[idx]);
            chk("hit_flags", {resp_miss, resp_invalid, resp_illegal}, 0);
            chk("hit_norefill", refill_valid, 0);
        end else begin
            refilled = 1'b1;
            flushed  = 1'b0;
            chk("miss_novalid", resp_valid, 0);
            chk("refill_valid", refill_valid, 1);
            chk("refill_vpn", refill_vpn, vpn);
            chk("refill_asid", refill_asid, as);
            for (int k = 0; k <= delay; k++) begin
                req_vaddr = $urandom; asid = 8'($urandom);
                if (k == delay) begin
                    refill_ready = 1'b1; refill_hit = jhit; refill_v = jv; refill_d = jd;
                    refill_c = jc; refill_pfn = jpfn; refill_g = jg(vpn);
                end else begin
                    refill_ready = 1'b0; refill_hit = 1'($urandom); refill_v = 1'($urandom);
                    refill_pfn = 20'($urandom);
                end
                flush = (k == flush_at);
                if (flush) begin flushed = 1'b1; m_flush(); end
                @(negedge clk);
                if (k < delay) begin
                    chk("refill_hold", refill_valid, 1);
                    chk("refill_vpn_hold", refill_vpn, vpn);
                    chk("refill_asid_hold", refill_asid, as);
                    chk("refill_wait", resp_valid, 0);
                end
            end
            refill_ready = 1'b0; flush = 1'b0;
            chk("rf_valid", resp_valid, 1);
            chk("rf_miss", resp_miss, !jhit);
            chk("rf_invalid", resp_invalid, jhit && !jv);
            chk("rf_paddr", resp_paddr, {jpfn, va[11:0]});
            chk("rf_ill", resp_illegal, 0);
            chk("rf_done", refill_valid, 0);
            if (jhit && jv) begin
                chk("rf_dirty", resp_dirty, jd);
                chk("rf_unc", resp_uncached, jc == 3'd2);
                if (!flushed) m_install(vpn, as, jpfn, jd, jc, jg(vpn));
            end
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_blocks_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        m_flush();
    endtask

    typedef struct {
        logic [31:0] va;
        logic        user;
        logic        k0u;
        logic [31:0] paddr;
        logic        unc;
        logic        dirty;
        logic        ill;
    } vec_t;

    vec_t vt[8];
    logic rf;

    initial begin
        vt[0] = '{32'h8000_1234, 0, 0, 32'h0000_1234, 0, 1, 0};
        vt[1] = '{32'h8000_1234, 0, 1, 32'h0000_1234, 1, 1, 0};
        vt[2] = '{32'hA123_4568, 0, 0, 32'h0123_4568, 1, 1, 0};
        vt[3] = '{32'hBFFF_FFFC, 0, 1, 32'h1FFF_FFFC, 1, 1, 0};
        vt[4] = '{32'h9FFF_0000, 0, 0, 32'h1FFF_0000, 0, 1, 0};
        vt[5] = '{32'hC000_0000, 1, 0, 32'h0000_0000, 0, 0, 1};
        vt[6] = '{32'h8000_0000, 1, 0, 32'h0000_0000, 0, 0, 1};
        vt[7] = '{32'hFFFF_F000, 1, 1, 32'h0000_0000, 0, 0, 1};

        reset = 1'b1; asid = '0; kseg0_uncached = 0; is_user_mode = 0; flush = 0;
        req_valid = 0; req_vaddr = '0; refill_ready = 0; refill_hit = 0; refill_pfn = '0;
        refill_v = 0; refill_d = 0; refill_c = '0; refill_g = 0;
        m_flush(); m_ptr = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {req_ready, resp_valid, refill_valid, resp_miss, resp_invalid,
                            resp_dirty, resp_uncached, resp_illegal}, 0);
        chk("rst_paddr", resp_paddr, 0);
        reset = 1'b0;
        #1 chk("ready_low_after_rst", req_ready, 0);
        @(negedge clk);
        chk("ready_rises", req_ready, 1);

        // Address-map and legality vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            is_user_mode = vt[i].user; kseg0_uncached = vt[i].k0u;
            req_vaddr = vt[i].va; asid = 8'd1; req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), resp_valid, 1);
            chk($sformatf("vec%0d_ill", i), resp_illegal, vt[i].ill);
            chk($sformatf("vec%0d_norefill", i), refill_valid, 0);
            if (!vt[i].ill) begin
                chk($sformatf("vec%0d_paddr", i), resp_paddr, vt[i].paddr);
                chk($sformatf("vec%0d_unc", i), resp_uncached, vt[i].unc);
                chk($sformatf("vec%0d_dirty", i), resp_dirty, vt[i].dirty);
            end else begin
                chk($sformatf("vec%0d_miss", i), {resp_miss, resp_invalid}, 0);
            end
        end
        is_user_mode = 1'b0;

        // Refill then cached hit
        txn(32'h0040_0010, 8'd5, 0, 0, 2, -1, 1, 1, 1, 3'd3, 20'h1F000, rf);
        chk("t2_refilled", rf, 1);
        chk("t2_paddr", resp_paddr, 32'h1F00_0010);
        txn(32'h0040_0010, 8'd5, 0, 0, 0, -1, 1, 1, 1, 3'd3, 20'h1F000, rf);
        chk("t2_hit", rf, 0);
        chk("t2_hit_paddr", resp_paddr, 32'h1F00_0010);

        // Joint-TLB miss is not cached
        txn(32'h0050_0020, 8'd5, 0, 0, 1, -1, 0, 0, 0, 3'd0, 20'h00000, rf);
        chk("t3_miss", resp_miss, 1);
        txn(32'h0050_0020, 8'd5, 0, 0, 0, -1, 1, 1, 0, 3'd2, 20'h00ABC, rf);
        chk("t3_refill_again", rf, 1);

        // Five pages into four slots: first page is evicted
        flush_pulse();
        for (int i = 0; i < 5; i++) begin
            txn({20'h01000 + 20'(i), 12'h040}, 8'd5, 0, 0, 0, -1, 1, 1, 0, 3'd3, 20'h20000 + 20'(i), rf);
            chk($sformatf("t4_fill%0d", i), rf, 1);
        end
        for (int i = 1; i < 5; i++) begin
            txn({20'h01000 + 20'(i), 12'h080}, 8'd5, 0, 0, 0, -1, 1, 1, 0, 3'd3, 20'h0, rf);
            chk($sformatf("t4_hit%0d", i), rf, 0);
        end
        txn({20'h01000, 12'h080}, 8'd5, 0, 0, 0, -1, 1, 1, 0, 3'd3, 20'h30000, rf);
        chk("t4_page0_evicted", rf, 1);

        // Flush while refill pending
        txn(32'h0060_0000, 8'd7, 0, 0, 3, 1, 1, 1, 1, 3'd3, 20'h12345, rf);
        chk("t5_delivered", resp_paddr, 32'h1234_5000);
        txn(32'h0060_0000, 8'd7, 0, 0, 0, -1, 1, 1, 1, 3'd3, 20'h12345, rf);
        chk("t5_not_installed", rf, 1);
        // Flush coinciding with the reply
        txn(32'h0070_0000, 8'd7, 0, 0, 1, 1, 1, 1, 1, 3'd3, 20'h22222, rf);
        txn(32'h0070_0000, 8'd7, 0, 0, 0, -1, 1, 1, 1, 3'd3, 20'h22222, rf);
        chk("t5_same_cycle_flush", rf, 1);

        // refill_ready in IDLE is ignored
        @(negedge clk);
        refill_ready = 1'b1; refill_hit = 1'b1; refill_v = 1'b1;
        @(negedge clk);
        refill_ready = 1'b0;
        chk("idle_reply_ignored", {resp_valid, refill_valid}, 0);

        // Reset in REFILL
        @(negedge clk);
        req_vaddr = 32'h0090_0000; asid = 8'd3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t6_in_refill", refill_valid, 1);
        #2 reset = 1'b1;
        #1 chk("t6_async_drop", refill_valid, 0);
        chk("t6_ready_rst", req_ready, 0);
        @(negedge clk);
        refill_ready = 1'b1; refill_hit = 1'b1; refill_v = 1'b1;
        @(negedge clk);
        refill_ready = 1'b0;
        reset = 1'b0;
        m_flush(); m_ptr = 0;
        @(negedge clk);
        chk("t6_no_resp", resp_valid, 0);
        chk("t6_ready_back", req_ready, 1);
        txn(32'h0040_0010, 8'd5, 0, 0, 0, -1, 1, 1, 1, 3'd3, 20'h1F000, rf);
        chk("t6_cache_cleared", rf, 1);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int          sel, j, dly, fat;
            logic [19:0] vpn;
            logic [31:0] va;
            logic        usr;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                flush_pulse();
            end else if (sel == 1) begin
                @(negedge clk);
                refill_ready = 1'b1; refill_hit = 1'b1; refill_v = 1'b1;
                @(negedge clk);
                refill_ready = 1'b0;
                chk("rnd_idle_reply", resp_valid, 0);
            end else begin
                usr = ($urandom_range(0, 9) == 0);
                if (sel < 4) begin
                    va = {($urandom_range(0, 1) != 0) ? 3'b101 : 3'b100, 29'($urandom)};
                end else begin
                    j   = $urandom_range(0, 7);
                    vpn = (j < 5) ? 20'h00400 + 20'(j) : 20'hC0000 + 20'(j);
                    va  = {vpn, 12'($urandom)};
                end
                dly = $urandom_range(0, 3);
                fat = ($urandom_range(0, 6) == 0) ? $urandom_range(0, dly) : -1;
                txn(va, 8'($urandom_range(1, 2)), usr, 1'($urandom), dly, fat,
                    $urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0, 1'($urandom),
                    3'($urandom), 20'($urandom), rf);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
